channel_serializer: RTL and testbench
=====================================

// Module: channel_serializer
// PURPOSE
//  Breaks one wide Channel word into NIN/NOUT narrow beats and emits them in order on a narrow Channel.
//  Sits upstream of the 32-bit dual-clock Channel FIFO and feeds it.
//  Typical use: 64-bit host words into the 32-bit FIFO path, 2 beats/word.
//  Full throughput: one beat per cycle under continuous out.a, no bubble between consecutive words.
// PARAMETERS
//  NIN       64  width of in.d; must be an integer multiple of NOUT (elaboration $error otherwise)
//  NOUT      32  width of out.d
//  LSB_FIRST 1   1: beat 0 = in.d[NOUT-1:0]; 0: beat 0 = in.d[NIN-1:NIN-NOUT]
//  (derived) K = NIN/NOUT beats per word; CW = max(1,$clog2(K)) beat-counter width
// PORTS
//  clk    input   1     single clock; all state on posedge clk
//  reset  input   1     asynchronous, active-low (0 = in reset); asserts immediately, released synchronously by upstream
//  in     Channel NIN   wide input: in.d/in.v driven by upstream, in.a driven here
//  out    Channel NOUT  narrow output: out.d/out.v driven here, out.a driven by downstream
// BEHAVIOUR
//  Handshake: a transfer occurs in any cycle where v==1 && a==1 on that channel.
//   in.a is combinational from in.v and state; out.a must not depend combinationally on out.v.
//  State: st in {IDLE, SEND}; buf[NIN-1:0] holds the word; cnt[CW-1:0] is the beat index.
//  Reset (reset==0, async): st=IDLE, cnt=0, buf=0.
//   Outputs while reset==0: out.v=0, out.d=0, in.a=0. All outputs are forced, not merely registered.
//  IDLE:
//   in.a = in.v; out.v = 0; out.d = 0.
//   On an in transfer: buf<=in.d, cnt<=0, st<=SEND.
//  SEND:
//   out.v = 1; out.d = buf slice cnt, as selected by LSB_FIRST.
//   out.a==0: hold buf and cnt; out.d stable (stall).
//   out.a==1 && cnt<K-1: cnt<=cnt+1.
//   out.a==1 && cnt==K-1 (last beat):
//    in.a = in.v.
//    If in.v==1: buf<=in.d, cnt<=0, stay SEND (zero-bubble chaining).
//    Otherwise: st<=IDLE, cnt<=0.
//   In SEND, in.a = 0 except on the last beat with out.a==1.
//  Latency: word accepted in cycle t; beat 0 valid in cycle t+1; beat K-1 in cycle t+K with no stalls.
//  K==1: degenerates to a 1-deep pipeline register. cnt is constant 0 and every beat is the last beat.
//  Reset mid-word: the partially sent word is discarded. After release, the block is in IDLE and waits for the next in.v.
//  No internal X: out.d is 0 whenever out.v==0.
//  Data is never dropped or duplicated except by reset.
// STRUCTURE
//  Shared package ChannelUtilPkg holds:
//   typedef enum logic {SER_IDLE, SER_SEND} ser_state_t
//   function ser_slice(word, idx, lsb_first), which returns the NOUT-bit beat.
//   DCChannelDeserializer (future) will reuse both.
//  Single module, no sub-module; two always_ff blocks (st/cnt, buf) plus one always_comb for outputs.
//  Uses the existing Channel interface. Upstream may place a ChannelFIFO in front for timing.
// TESTING (NIN=64, NOUT=16, K=4 unless noted)
//  1 reset=0, in.v=1 -> in.a=0, out.v=0, out.d=0. Release -> IDLE, in.a=1 the same cycle.
//  2 single word 64'h0123_4567_89AB_CDEF with out.a=1 -> out.d=CDEF,89AB,4567,0123 in cycles t+1..t+4; out.v=0 at t+5.
//  3 two words back-to-back, out.a held 1 -> 8 contiguous valid beats; in.a for word 2 pulses in the cycle of word 1's 4th beat.
//  4 out.a=0 for 3 cycles after beat 1 -> out.d stays 89AB, in.a=0. Sequence then resumes 4567,0123 with nothing lost.
//  5 LSB_FIRST=0, same word -> 0123,4567,89AB,CDEF.
//  6 reset pulsed low after beat 1 (async, mid-cycle) -> out.v drops immediately. After release, next word 64'hFFFF_0000_AAAA_5555 emits 5555 first.
//  Bench checks with a scoreboard:
//   beats match the expected slices under random out.a;
//   out.d stable while out.v && !out.a;
//   K=1 configuration passes tests 2-4.

Source files
------------

// File: rtl/channel_serializer_pkg.sv
// Shared types and helpers for wide/narrow Channel conversion blocks.
package channel_serializer_pkg;

    // Serializer control state.
    typedef enum logic {
        SerIdle = 1'b0,
        SerSend = 1'b1
    } ser_state_t;

    // Maps a beat index to the slice position inside the wide word.
    // Position p selects bits [p*NOUT +: NOUT] of the word.
    function automatic int unsigned ser_beat_pos(
        input int unsigned idx,
        input int unsigned k,
        input bit          lsb_first
    );
        return lsb_first ? idx : (k - 1 - idx);
    endfunction

endpackage

// File: rtl/channel_serializer.sv
// Splits one NIN-bit Channel word into K = NIN/NOUT narrow beats, emitted in order.
// Consecutive words chain without a bubble when the next word is offered on the last beat.
module channel_serializer
    import channel_serializer_pkg::*;
#(
    parameter int unsigned NIN       = 64,
    parameter int unsigned NOUT      = 32,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIN-1:0]  in_d,
    input  logic            in_v,
    output logic            in_a,
    output logic [NOUT-1:0] out_d,
    output logic            out_v,
    input  logic            out_a
);

    localparam int unsigned K        = NIN / NOUT;
    localparam int unsigned CW       = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned BW       = (NIN > 1) ? $clog2(NIN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

    if ((NIN % NOUT) != 0) begin : g_bad_width
        $error("channel_serializer: NIN (%0d) must be a multiple of NOUT (%0d)", NIN, NOUT);
    end

    ser_state_t      st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NIN-1:0]  word_q;
    logic            load;
    int unsigned     beat_pos;
    logic [BW-1:0]   beat_base;
    logic [NOUT-1:0] beat;

    // Current beat slice of the held word.
    assign beat_pos  = ser_beat_pos(32'(cnt_q), K, LSB_FIRST);
    assign beat_base = BW'(beat_pos * NOUT);
    assign beat      = word_q[beat_base +: NOUT];

    // Control state and beat index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= SerIdle;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Word buffer, loaded on every accepted input word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= in_d;
        end
    end

    // Handshakes, beat output and next state; everything is forced idle while in reset.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        load  = 1'b0;
        in_a  = 1'b0;
        out_v = 1'b0;
        out_d = '0;

        unique case (st_q)
            SerIdle: begin
                in_a = in_v;
                if (in_v) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    st_d  = SerSend;
                end
            end
            SerSend: begin
                out_v = 1'b1;
                out_d = beat;
                if (out_a) begin
                    if (cnt_q == LAST_IDX) begin
                        // Last beat leaves: the next word may enter in the same cycle.
                        in_a  = in_v;
                        cnt_d = '0;
                        if (in_v) begin
                            load = 1'b1;
                        end else begin
                            st_d = SerIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                st_d  = SerIdle;
                cnt_d = '0;
            end
        endcase

        if (!reset) begin
            in_a  = 1'b0;
            out_v = 1'b0;
            out_d = '0;
            load  = 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_serializer.sv
// Directed and scoreboard checks for channel_serializer (64->16 both orders, and 32->32).
module tb_channel_serializer;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_d  = '0;
    logic        in_v  = 1'b0;
    logic        out_a = 1'b0;

    logic        in_a_l, out_v_l, in_a_m, out_v_m;
    logic [15:0] out_d_l, out_d_m;

    logic [31:0] k1_in_d  = '0;
    logic        k1_in_v  = 1'b0;
    logic        k1_out_a = 1'b0;
    logic        k1_in_a, k1_out_v;
    logic [31:0] k1_out_d;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] W1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] W3 = 64'hFFFF_0000_AAAA_5555;

    logic [15:0] w1_lsb [4] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    logic [15:0] w1_msb [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [15:0] w2_lsb [4] = '{16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};
    logic [15:0] w3_lsb [4] = '{16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF};

    always #5 clk = ~clk;

    channel_serializer #(.NIN(64), .NOUT(16), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a_l),
        .out_d(out_d_l), .out_v(out_v_l), .out_a(out_a)
    );

    channel_serializer #(.NIN(64), .NOUT(16), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a_m),
        .out_d(out_d_m), .out_v(out_v_m), .out_a(out_a)
    );

    channel_serializer #(.NIN(32), .NOUT(32), .LSB_FIRST(1'b1)) dut_k1 (
        .clk(clk), .reset(reset), .in_d(k1_in_d), .in_v(k1_in_v), .in_a(k1_in_a),
        .out_d(k1_out_d), .out_v(k1_out_v), .out_a(k1_out_a)
    );

    // Inputs change on the falling edge; outputs are inspected 1 time unit later.
    task automatic drive(input logic v, input logic [63:0] d, input logic a);
        @(negedge clk);
        in_v  = v;
        in_d  = d;
        out_a = a;
        #1;
    endtask

    task automatic drive_k1(input logic v, input logic [31:0] d, input logic a);
        @(negedge clk);
        k1_in_v  = v;
        k1_in_d  = d;
        k1_out_a = a;
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        k1_in_v = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, W1, 1'b1);
            n_cmp++; if (in_a_l !== 1'b0) begin n_err++; $display("FAIL reset in_a got %b want 0", in_a_l); end
            n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL reset out_v got %b want 0", out_v_l); end
            n_cmp++; if (out_d_l !== 16'h0) begin n_err++; $display("FAIL reset out_d got %h want 0", out_d_l); end
            n_cmp++; if (k1_in_a !== 1'b0) begin n_err++; $display("FAIL reset k1 in_a got %b want 0", k1_in_a); end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (in_a_l !== 1'b1) begin n_err++; $display("FAIL release in_a got %b want 1", in_a_l); end
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL release out_v got %b want 0", out_v_l); end
        in_v    = 1'b0;
        k1_in_v = 1'b0;
        drive(1'b0, 64'h0, 1'b1);
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL idle out_v got %b want 0", out_v_l); end
    endtask

    task automatic test_single();
        drive(1'b1, W1, 1'b1);
        n_cmp++; if (in_a_l !== 1'b1) begin n_err++; $display("FAIL single in_a got %b want 1", in_a_l); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            n_cmp++; if (out_v_l !== 1'b1) begin n_err++; $display("FAIL single out_v beat%0d got %b want 1", i, out_v_l); end
            n_cmp++; if (out_d_l !== w1_lsb[i]) begin n_err++; $display("FAIL single out_d beat%0d got %h want %h", i, out_d_l, w1_lsb[i]); end
            n_cmp++; if (in_a_l !== 1'b0) begin n_err++; $display("FAIL single in_a beat%0d got %b want 0", i, in_a_l); end
        end
        drive(1'b0, 64'h0, 1'b1);
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL single tail out_v got %b want 0", out_v_l); end
        n_cmp++; if (out_d_l !== 16'h0) begin n_err++; $display("FAIL single tail out_d got %h want 0", out_d_l); end
    endtask

    task automatic test_msb_first();
        drive(1'b1, W1, 1'b1);
        n_cmp++; if (in_a_m !== 1'b1) begin n_err++; $display("FAIL msb in_a got %b want 1", in_a_m); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            n_cmp++; if (out_d_m !== w1_msb[i]) begin n_err++; $display("FAIL msb out_d beat%0d got %h want %h", i, out_d_m, w1_msb[i]); end
        end
        drive(1'b0, 64'h0, 1'b1);
        n_cmp++; if (out_v_m !== 1'b0) begin n_err++; $display("FAIL msb tail out_v got %b want 0", out_v_m); end
    endtask

    task automatic test_back_to_back();
        logic exp_a;
        drive(1'b1, W1, 1'b1);
        n_cmp++; if (in_a_l !== 1'b1) begin n_err++; $display("FAIL b2b first in_a got %b want 1", in_a_l); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W2, 1'b1);
            exp_a = (i == 3);
            n_cmp++; if (out_d_l !== w1_lsb[i]) begin n_err++; $display("FAIL b2b w1 out_d beat%0d got %h want %h", i, out_d_l, w1_lsb[i]); end
            n_cmp++; if (in_a_l !== exp_a) begin n_err++; $display("FAIL b2b in_a beat%0d got %b want %b", i, in_a_l, exp_a); end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            n_cmp++; if (out_v_l !== 1'b1) begin n_err++; $display("FAIL b2b w2 out_v beat%0d got %b want 1", i, out_v_l); end
            n_cmp++; if (out_d_l !== w2_lsb[i]) begin n_err++; $display("FAIL b2b w2 out_d beat%0d got %h want %h", i, out_d_l, w2_lsb[i]); end
        end
        drive(1'b0, 64'h0, 1'b1);
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL b2b tail out_v got %b want 0", out_v_l); end
    endtask

    task automatic test_stall();
        drive(1'b1, W1, 1'b1);
        drive(1'b0, 64'h0, 1'b1);
        n_cmp++; if (out_d_l !== 16'hCDEF) begin n_err++; $display("FAIL stall beat0 got %h want cdef", out_d_l); end
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, W2, 1'b0);
            n_cmp++; if (out_v_l !== 1'b1) begin n_err++; $display("FAIL stall%0d out_v got %b want 1", s, out_v_l); end
            n_cmp++; if (out_d_l !== 16'h89AB) begin n_err++; $display("FAIL stall%0d out_d got %h want 89ab", s, out_d_l); end
            n_cmp++; if (in_a_l !== 1'b0) begin n_err++; $display("FAIL stall%0d in_a got %b want 0", s, in_a_l); end
        end
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            n_cmp++; if (out_d_l !== w1_lsb[i]) begin n_err++; $display("FAIL stall resume beat%0d got %h want %h", i, out_d_l, w1_lsb[i]); end
        end
        drive(1'b0, 64'h0, 1'b1);
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL stall tail out_v got %b want 0", out_v_l); end
    endtask

    task automatic test_reset_mid_word();
        drive(1'b1, W1, 1'b1);
        drive(1'b0, 64'h0, 1'b1);
        drive(1'b1, W2, 1'b1);
        n_cmp++; if (out_d_l !== 16'h89AB) begin n_err++; $display("FAIL midrst beat1 got %h want 89ab", out_d_l); end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL midrst out_v got %b want 0", out_v_l); end
        n_cmp++; if (out_d_l !== 16'h0) begin n_err++; $display("FAIL midrst out_d got %h want 0", out_d_l); end
        n_cmp++; if (in_a_l !== 1'b0) begin n_err++; $display("FAIL midrst in_a got %b want 0", in_a_l); end
        drive(1'b0, 64'h0, 1'b1);
        reset = 1'b1;
        #1;
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL midrst release out_v got %b want 0", out_v_l); end
        drive(1'b1, W3, 1'b1);
        n_cmp++; if (in_a_l !== 1'b1) begin n_err++; $display("FAIL midrst w3 in_a got %b want 1", in_a_l); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            n_cmp++; if (out_d_l !== w3_lsb[i]) begin n_err++; $display("FAIL midrst w3 beat%0d got %h want %h", i, out_d_l, w3_lsb[i]); end
        end
        drive(1'b0, 64'h0, 1'b1);
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL midrst tail out_v got %b want 0", out_v_l); end
    endtask

    // Random in_v/out_a; every accepted word is queued as four expected slices.
    task automatic test_random_scoreboard();
        logic [15:0] q[$];
        logic [15:0] exp_d;
        logic [15:0] prev_d = '0;
        logic        prev_stall = 1'b0;
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            in_v  = ($urandom_range(0, 2) != 0);
            in_d  = {$urandom(), $urandom()};
            out_a = (c < 300) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (c >= 300) in_v = 1'b0;
            #1;
            if (prev_stall) begin
                n_cmp++;
                if (out_v_l !== 1'b1 || out_d_l !== prev_d) begin
                    n_err++; $display("FAIL sb stable c%0d got v=%b d=%h want v=1 d=%h", c, out_v_l, out_d_l, prev_d);
                end
            end
            if (out_v_l === 1'b1 && out_a) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL sb extra beat c%0d got %h want none", c, out_d_l);
                end else begin
                    exp_d = q.pop_front();
                    if (out_d_l !== exp_d) begin n_err++; $display("FAIL sb beat c%0d got %h want %h", c, out_d_l, exp_d); end
                end
            end
            if (in_v && in_a_l === 1'b1) begin
                for (int b = 0; b < 4; b++) q.push_back(in_d[b*16 +: 16]);
            end
            prev_stall = (out_v_l === 1'b1) && !out_a;
            prev_d     = out_d_l;
        end
        n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL sb leftover beats got %0d want 0", q.size()); end
        n_cmp++; if (out_v_l !== 1'b0) begin n_err++; $display("FAIL sb drained out_v got %b want 0", out_v_l); end
        drive(1'b0, 64'h0, 1'b1);
    endtask

    task automatic test_k1();
        // Single word.
        drive_k1(1'b1, 32'h1234_5678, 1'b1);
        n_cmp++; if (k1_in_a !== 1'b1) begin n_err++; $display("FAIL k1 single in_a got %b want 1", k1_in_a); end
        n_cmp++; if (k1_out_v !== 1'b0) begin n_err++; $display("FAIL k1 single pre out_v got %b want 0", k1_out_v); end
        drive_k1(1'b0, 32'h0, 1'b1);
        n_cmp++; if (k1_out_d !== 32'h1234_5678) begin n_err++; $display("FAIL k1 single out_d got %h want 12345678", k1_out_d); end
        drive_k1(1'b0, 32'h0, 1'b1);
        n_cmp++; if (k1_out_v !== 1'b0) begin n_err++; $display("FAIL k1 single tail out_v got %b want 0", k1_out_v); end
        // Back-to-back.
        drive_k1(1'b1, 32'hAAAA_0001, 1'b1);
        drive_k1(1'b1, 32'hBBBB_0002, 1'b1);
        n_cmp++; if (k1_out_d !== 32'hAAAA_0001) begin n_err++; $display("FAIL k1 b2b A got %h want aaaa0001", k1_out_d); end
        n_cmp++; if (k1_in_a !== 1'b1) begin n_err++; $display("FAIL k1 b2b in_a got %b want 1", k1_in_a); end
        drive_k1(1'b1, 32'hCCCC_0003, 1'b1);
        n_cmp++; if (k1_out_d !== 32'hBBBB_0002) begin n_err++; $display("FAIL k1 b2b B got %h want bbbb0002", k1_out_d); end
        drive_k1(1'b0, 32'h0, 1'b1);
        n_cmp++; if (k1_out_d !== 32'hCCCC_0003) begin n_err++; $display("FAIL k1 b2b C got %h want cccc0003", k1_out_d); end
        drive_k1(1'b0, 32'h0, 1'b1);
        n_cmp++; if (k1_out_v !== 1'b0) begin n_err++; $display("FAIL k1 b2b tail out_v got %b want 0", k1_out_v); end
        // Stall.
        drive_k1(1'b1, 32'hD00D_0004, 1'b1);
        for (int s = 0; s < 3; s++) begin
            drive_k1(1'b1, 32'hEEEE_0005, 1'b0);
            n_cmp++; if (k1_out_d !== 32'hD00D_0004) begin n_err++; $display("FAIL k1 stall%0d out_d got %h want d00d0004", s, k1_out_d); end
            n_cmp++; if (k1_in_a !== 1'b0) begin n_err++; $display("FAIL k1 stall%0d in_a got %b want 0", s, k1_in_a); end
        end
        drive_k1(1'b0, 32'h0, 1'b1);
        n_cmp++; if (k1_out_d !== 32'hD00D_0004) begin n_err++; $display("FAIL k1 resume got %h want d00d0004", k1_out_d); end
        drive_k1(1'b0, 32'h0, 1'b1);
        n_cmp++; if (k1_out_v !== 1'b0) begin n_err++; $display("FAIL k1 stall tail out_v got %b want 0", k1_out_v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_msb_first();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_random_scoreboard();
        test_k1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
